// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the ALU operation, selects operand B and
// registers the bundle for Execute, with load-use stalling, flush and hold.
module alu_issue_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               InstrD,
    input  logic                      ValidD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic                      HoldE,
    input  logic                      FlushE,
    output logic                      StallD,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     SrcBE,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [2:0]                ALUControlE,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic                      RegWriteE,
    output logic                      MemReadE,
    output logic                      MemWriteE,
    output logic                      BranchE,
    output logic                      ValidE,
    output logic                      IllegalE
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic                      valid;
        logic                      ill;
        logic                      rw;
        logic                      mr;
        logic                      mw;
        logic                      br;
        logic [2:0]                alu;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     srcb;
        logic [DATA_WIDTH-1:0]     rd2;
    } e_t;

    e_t e_q, e_d, dec;

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic                      alt;
    logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
    logic                      is_r, is_i, is_ld, is_st, is_br, is_lui;
    logic                      ill, uses_rs2, uses_imm, writes;
    logic [2:0]                alu;
    logic                      hazard;
    logic                      unused_bits;

    assign opcode      = InstrD[6:0];
    assign funct3      = InstrD[14:12];
    assign alt         = InstrD[30];
    assign rd          = REG_ADDR_WIDTH'(InstrD[11:7]);
    assign rs1         = REG_ADDR_WIDTH'(InstrD[19:15]);
    assign rs2         = REG_ADDR_WIDTH'(InstrD[24:20]);
    assign unused_bits = ^{InstrD[31], InstrD[29:25]};

    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_ld  = (opcode == OP_LOAD);
    assign is_st  = (opcode == OP_STORE);
    assign is_br  = (opcode == OP_BRANCH);
    assign is_lui = (opcode == OP_LUI);

    assign uses_rs2 = is_r | is_st | is_br;
    assign uses_imm = is_i | is_ld | is_st | is_lui;
    assign writes   = is_r | is_i | is_ld | is_lui;

    always_comb begin
        alu = 3'b000;
        ill = 1'b0;
        if (is_r || is_i) begin
            case (funct3)
                3'b000: alu = (is_r && alt) ? 3'b001 : 3'b000;
                3'b111: alu = 3'b010;
                3'b110: alu = 3'b011;
                3'b100: alu = 3'b100;
                3'b001: alu = 3'b110;
                3'b101: begin
                    alu = 3'b111;
                    ill = alt;
                end
                default: ill = 1'b1;
            endcase
        end else if (is_ld || is_st) begin
            alu = 3'b000;
        end else if (is_br) begin
            alu = 3'b001;
            ill = (funct3 != 3'b001);
        end else if (is_lui) begin
            alu = 3'b101;
        end else begin
            ill = 1'b1;
        end
    end

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.ill   = ill;
        dec.alu   = ill ? 3'b000 : alu;
        dec.rw    = writes & ~ill & (rd != '0);
        dec.mr    = is_ld;
        dec.mw    = is_st;
        dec.br    = is_br & ~ill;
        dec.rd    = rd;
        dec.rd1   = RD1D;
        dec.srcb  = uses_imm ? ImmExtD : RD2D;
        dec.rd2   = RD2D;
    end

    // The load sitting in E is the only producer that can't forward in time.
    assign hazard = e_q.valid & e_q.mr & (e_q.rd != '0) & ValidD &
                    ((e_q.rd == rs1) | (uses_rs2 & (e_q.rd == rs2)));

    assign StallD = ~rst & (hazard | HoldE);

    always_comb begin
        e_d = dec;
        if (FlushE) begin
            e_d = '0;
        end else if (HoldE) begin
            e_d = e_q;
        end else if (hazard || !ValidD) begin
            e_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign RD1E        = e_q.rd1;
    assign SrcBE       = e_q.srcb;
    assign RD2E        = e_q.rd2;
    assign ALUControlE = e_q.alu;
    assign RdE         = e_q.rd;
    assign RegWriteE   = e_q.rw;
    assign MemReadE    = e_q.mr;
    assign MemWriteE   = e_q.mw;
    assign BranchE     = e_q.br;
    assign ValidE      = e_q.valid;
    assign IllegalE    = e_q.ill;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the Execute-stage ALU interface: decodes the Decode-stage instruction into the 3-bit ALU control code and selects the second operand.
- Registers everything into the ID/EX pipeline register that drives RD1E, SrcBE and ALUControlE.
- Owns load-use hazard detection, bubble insertion, flush and hold, so the ALU always sees a well-formed operation or a bubble.

Parameters:
DATA_WIDTH, 32, operand/immediate width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
InstrD  in  32  Decode-stage instruction
ValidD  in  1  InstrD holds a real instruction
RD1D  in  DATA_WIDTH  register-file read data rs1
RD2D  in  DATA_WIDTH  register-file read data rs2
ImmExtD  in  DATA_WIDTH  sign-extended immediate
HoldE  in  1  downstream back-pressure; freeze ID/EX
FlushE  in  1  branch taken; kill the instruction entering E
StallD  out  1  freeze PC and IF/ID (combinational)
RD1E  out  DATA_WIDTH  ALU operand A
SrcBE  out  DATA_WIDTH  ALU operand B
RD2E  out  DATA_WIDTH  store data
ALUControlE  out  3  ALU operation code
RdE  out  REG_ADDR_WIDTH  destination register
RegWriteE  out  1  writeback enable
MemReadE  out  1  load in E
MemWriteE  out  1  store in E
BranchE  out  1  bne in E (consumer uses ZeroE)
ValidE  out  1  E holds a real instruction
IllegalE  out  1  E holds an undecodable instruction

Behaviour:
- Reset: all E outputs 0 (ALUControlE=000, ValidE=0, IllegalE=0). StallD is 0 while rst=1.
- ALU code decode (combinational on InstrD):
  - opcode 0110011 (R): funct3 000 with funct7[5]=0 -> 000 add; with funct7[5]=1 -> 001 sub; 111 -> 010 and; 110 -> 011 or; 100 -> 100 xor; 001 -> 110 sll; 101 with funct7[5]=0 -> 111 srl.
  - opcode 0010011 (I): same mapping, but addi ignores funct7.
  - 0000011 load, 0100011 store: add.
  - 1100011 branch, funct3 001 (bne): sub.
  - 0110111 LUI: 101, pass-through of SrcBE.
  - Anything else, including sra/srai and other branch funct3: IllegalE=1 and all write enables 0.
- SrcBE selects ImmExtD for I-type, load, store and LUI; RD2D for R-type and branch.
- Load-use hazard, all of the following true:
  - ValidE and MemReadE;
  - RdE != 0;
  - ValidD;
  - RdE == rs1 of InstrD, or RdE == rs2 of InstrD when InstrD uses rs2 (R, store, branch).
- StallD = hazard OR HoldE.
- Register update priority each edge:
  1. rst: clear.
  2. FlushE: bubble (ValidE=0, RegWriteE=MemReadE=MemWriteE=BranchE=IllegalE=0, ALUControlE=000, data outputs don't-care but zeroed). Wins over HoldE.
  3. HoldE: all E registers keep their value.
  4. Hazard: bubble.
  5. Otherwise: load the decoded D values. ValidD=0 loads a bubble.
- Latency: one cycle D->E. Throughput one per cycle with no hazard.
- A load-use stall lasts exactly one cycle, because the bubble clears MemReadE.
- HoldE during a hazard holds the load in E and keeps StallD high. The bubble is inserted on the first cycle HoldE drops.
- Rd=x0: RegWriteE forced 0. No hazard is raised on x0.
- Reset mid-stall: next cycle ValidE=0, StallD=0.

Test Plan:
- R-type sub x3,x1,x2 with RD1D=10, RD2D=3 -> next cycle ALUControlE=001, RD1E=10, SrcBE=3, RdE=3, RegWriteE=1, ValidE=1.
- LUI x5 with ImmExtD=0x12345000 -> ALUControlE=101, SrcBE=0x12345000, RegWriteE=1.
- lw x4 followed by add x6,x4,x1 -> StallD=1 for exactly one cycle; E shows a bubble, then the add with ALUControlE=000; the add enters E only once.
- bne in E, FlushE=1 while addi is in D -> next cycle ValidE=0, RegWriteE=0, ALUControlE=000.
- HoldE=1 for 3 cycles while xor is in E -> E outputs unchanged, StallD=1. FlushE with HoldE -> bubble.
- Opcode 1111111 -> IllegalE=1, RegWriteE=0, MemWriteE=0. lw x0 followed by a use of x0 -> no stall. rst asserted during a stall -> all E outputs 0 next cycle.
